// File: rtl/jt12_ch_wrdec.sv
// CPU write decoder for the channel-level registers (0xA0-0xB6) of a YM2612-style core.
// Optional build macro JT12_BUSY_BLOCK_EN: data writes arriving while busy are dropped.
module jt12_ch_wrdec #(
    parameter int NUM_CH      = 6,
    parameter int BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic [7:0] dout,
    output logic [2:0] up_ch,
    output logic [5:0] latch_fnum,
    output logic [7:0] reg_din,
    output logic       up_fnumlo,
    output logic       up_alg,
    output logic       up_pms
);

    localparam int CW = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);
    localparam bit HAS_PART2 = (NUM_CH == 6);

    logic [7:0]    reg_addr;
    logic          part;
    logic [CW-1:0] busy_cnt;
    logic          busy;
    logic          addr_wr;
    logic          data_wr;
    logic          data_acc;
    logic [1:0]    ch_sel;
    logic          ch_ok;
    logic [2:0]    ch_num;
    logic          sel_fnumhi;
    logic          sel_fnumlo;
    logic          sel_alg;
    logic          sel_pms;

    assign busy    = (busy_cnt != '0);
    assign dout    = {busy, 7'd0};
    assign addr_wr = write & ~addr[0];
    assign data_wr = write & addr[0];

`ifdef JT12_BUSY_BLOCK_EN
    assign data_acc = data_wr & ~busy;
`else
    assign data_acc = data_wr;
`endif

    // Register decode works on the address latched by the previous address write.
    always_comb begin
        ch_sel     = reg_addr[1:0];
        ch_ok      = (ch_sel != 2'd3) && !(part && !HAS_PART2);
        ch_num     = part ? ({1'b0, ch_sel} + 3'd3) : {1'b0, ch_sel};
        sel_fnumhi = ch_ok && (reg_addr[7:2] == 6'h29);
        sel_fnumlo = ch_ok && (reg_addr[7:2] == 6'h28);
        sel_alg    = ch_ok && (reg_addr[7:2] == 6'h2C);
        sel_pms    = ch_ok && (reg_addr[7:2] == 6'h2D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_addr <= 8'd0;
            part     <= 1'b0;
        end else if (addr_wr) begin
            reg_addr <= din;
            part     <= addr[1];
        end
    end

    // Strobes are one clk wide; reg_din and up_ch hold until the next accepted data write.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_din    <= 8'd0;
            latch_fnum <= 6'd0;
            up_ch      <= 3'd0;
            up_fnumlo  <= 1'b0;
            up_alg     <= 1'b0;
            up_pms     <= 1'b0;
        end else begin
            up_fnumlo <= 1'b0;
            up_alg    <= 1'b0;
            up_pms    <= 1'b0;
            if (data_acc) begin
                reg_din   <= din;
                up_fnumlo <= sel_fnumlo;
                up_alg    <= sel_alg;
                up_pms    <= sel_pms;
                if (ch_ok)
                    up_ch <= ch_num;
                if (sel_fnumhi)
                    latch_fnum <= din[5:0];
            end
        end
    end

    // Reload takes priority over the cen-driven decrement.
    always_ff @(posedge clk) begin
        if (rst)
            busy_cnt <= '0;
        else if (data_acc)
            busy_cnt <= BUSY_LOAD;
        else if (cen && busy)
            busy_cnt <= busy_cnt - 1'b1;
    end

endmodule
